cache_data_bank: RTL and testbench



---
 rtl/cache_data_bank.sv | 176 +++++++++++++++++
 tb/tb_cache_data_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_data_bank.sv
// Multi-way cache data storage: all-ways synchronous read, byte-strobed store-hit
// writes, and a burst refill engine that commits a full line to the victim way.
module cache_data_bank #(
    parameter  int NUM_WAYS   = 4,
    parameter  int NUM_SETS   = 8,
    parameter  int WORD_WIDTH = 32,
    parameter  int LINE_WORDS = 8,
    localparam int SET_W      = $clog2(NUM_SETS),
    localparam int WAY_W      = $clog2(NUM_WAYS),
    localparam int OFF_W      = $clog2(LINE_WORDS),
    localparam int LINE_W     = WORD_WIDTH * LINE_WORDS,
    localparam int STRB_W     = WORD_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       rd_en,
    input  logic [SET_W-1:0]           rd_set,
    output logic [NUM_WAYS*LINE_W-1:0] rd_data,
    output logic                       rd_valid,
    input  logic                       wr_en,
    input  logic [WAY_W-1:0]           wr_way,
    input  logic [SET_W-1:0]           wr_set,
    input  logic [OFF_W-1:0]           wr_offset,
    input  logic [WORD_WIDTH-1:0]      wr_data,
    input  logic [STRB_W-1:0]          wr_strb,
    output logic                       wr_ready,
    input  logic                       refill_start,
    input  logic [WAY_W-1:0]           refill_way,
    input  logic [SET_W-1:0]           refill_set,
    input  logic                       refill_valid,
    input  logic [WORD_WIDTH-1:0]      refill_data,
    input  logic                       refill_last,
    output logic                       refill_ready,
    output logic                       refill_done,
    output logic                       refill_err,
    output logic                       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    logic [LINE_W-1:0]           mem_q [NUM_WAYS][NUM_SETS];
    state_e                      state_q, state_d;
    logic [OFF_W-1:0]            cnt_q, cnt_d;
    logic [LINE_W-1:0]           buf_q, buf_d;
    logic [WAY_W-1:0]            way_q, way_d;
    logic [SET_W-1:0]            set_q, set_d;
    logic                        err_acc_q, err_acc_d;
    logic                        busy_q, refill_ready_q, done_q, err_q;
    logic [NUM_WAYS*LINE_W-1:0]  rd_data_q;
    logic                        rd_valid_q;
    logic                        wr_ready_s, wr_fire_s, beat_acc_s;

    assign wr_ready_s   = (state_q == ST_IDLE) && !refill_start;
    assign wr_fire_s    = wr_en && wr_ready_s;
    assign beat_acc_s   = refill_valid && (state_q == ST_FILL);

    assign wr_ready     = wr_ready_s;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign refill_ready = refill_ready_q;
    assign refill_done  = done_q;
    assign refill_err   = err_q;
    assign busy         = busy_q;

    // Refill FSM next-state, beat assembly and last-marker tracking
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        way_d     = way_q;
        set_d     = set_q;
        err_acc_d = err_acc_q;
        case (state_q)
            ST_IDLE: begin
                if (refill_start) begin
                    state_d   = ST_FILL;
                    way_d     = refill_way;
                    set_d     = refill_set;
                    cnt_d     = '0;
                    err_acc_d = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (beat_acc_s) begin
                    buf_d[int'(cnt_q)*WORD_WIDTH +: WORD_WIDTH] = refill_data;
                    cnt_d = cnt_q + OFF_W'(1);
                    // An early last does not end the burst; it only flags an error.
                    if (refill_last != (cnt_q == LAST_BEAT)) begin
                        err_acc_d = 1'b1;
                    end else begin
                        err_acc_d = err_acc_q;
                    end
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state and registered status outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            buf_q          <= '0;
            way_q          <= '0;
            set_q          <= '0;
            err_acc_q      <= 1'b0;
            busy_q         <= 1'b0;
            refill_ready_q <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            buf_q          <= buf_d;
            way_q          <= way_d;
            set_q          <= set_d;
            err_acc_q      <= err_acc_d;
            busy_q         <= (state_d != ST_IDLE);
            refill_ready_q <= (state_d == ST_FILL);
            done_q         <= (state_d == ST_COMMIT);
            err_q          <= (state_d == ST_COMMIT) && err_acc_d;
        end
    end

    // Registered all-ways read; nonblocking update gives read-before-write
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    rd_data_q[w*LINE_W +: LINE_W] <= mem_q[w][rd_set];
                end
            end
        end
    end

    // Storage array (not reset): line commit or byte-merged store-hit write
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (state_q == ST_COMMIT) begin
                mem_q[way_q][set_q] <= buf_q;
            end else if (wr_fire_s) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_strb[b]) begin
                        mem_q[wr_way][wr_set][int'(wr_offset)*WORD_WIDTH + b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_data_bank.sv
// Directed self-checking bench for cache_data_bank with hand-computed expectations.
module tb_cache_data_bank;

    localparam int NW = 4;
    localparam int NS = 8;
    localparam int WW = 32;
    localparam int LW = 8;
    localparam int LINE_W = WW * LW;

    logic              clk = 1'b0;
    logic              resetn;
    logic              rd_en;
    logic [2:0]        rd_set;
    logic [NW*LINE_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_en;
    logic [1:0]        wr_way;
    logic [2:0]        wr_set;
    logic [2:0]        wr_offset;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              wr_ready;
    logic              refill_start;
    logic [1:0]        refill_way;
    logic [2:0]        refill_set;
    logic              refill_valid;
    logic [31:0]       refill_data;
    logic              refill_last;
    logic              refill_ready;
    logic              refill_done;
    logic              refill_err;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    cache_data_bank #(.NUM_WAYS(NW), .NUM_SETS(NS), .WORD_WIDTH(WW), .LINE_WORDS(LW)) dut (
        .clk(clk), .resetn(resetn),
        .rd_en(rd_en), .rd_set(rd_set), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_way(wr_way), .wr_set(wr_set), .wr_offset(wr_offset),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_ready(wr_ready),
        .refill_start(refill_start), .refill_way(refill_way), .refill_set(refill_set),
        .refill_valid(refill_valid), .refill_data(refill_data), .refill_last(refill_last),
        .refill_ready(refill_ready), .refill_done(refill_done), .refill_err(refill_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input int way, input int off);
        return rd_data[(way*LW + off)*WW +: WW];
    endfunction

    task automatic read_set(input logic [2:0] s);
        rd_en  = 1'b1;
        rd_set = s;
        tick();
        rd_en  = 1'b0;
        check_val("rd_valid", 64'(rd_valid), 64'd1);
    endtask

    task automatic do_write(input logic [1:0] w, input logic [2:0] s, input logic [2:0] o,
                            input logic [31:0] d, input logic [3:0] st);
        wr_en = 1'b1; wr_way = w; wr_set = s; wr_offset = o; wr_data = d; wr_strb = st;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_refill(input logic [1:0] w, input logic [2:0] s);
        refill_start = 1'b1; refill_way = w; refill_set = s;
        tick();
        refill_start = 1'b0;
        check_val("busy_fill", 64'(busy), 64'd1);
        check_val("ready_fill", 64'(refill_ready), 64'd1);
    endtask

    // Sends beats first_k..first_k+n-1; toggle inserts an idle cycle between beats.
    task automatic send_beats(input logic [31:0] base, input int first_k, input int n,
                              input bit toggle, input int last_beat);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < 64) begin
            logic v;
            int   k;
            k = first_k + acc;
            v = toggle ? ((cyc % 2) == 0) : 1'b1;
            refill_valid = v;
            refill_data  = base + 32'(k);
            refill_last  = (k == last_beat);
            if (v && refill_ready && !refill_done) acc++;
            tick();
            cyc++;
        end
        refill_valid = 1'b0;
        refill_last  = 1'b0;
        check_val("beats_accepted", 64'(acc), 64'(n));
    endtask

    task automatic finish_commit(input logic exp_err);
        check_val("done_pulse", 64'(refill_done), 64'd1);
        check_val("err_pulse", 64'(refill_err), 64'(exp_err));
        check_val("ready_commit", 64'(refill_ready), 64'd0);
        tick();
        check_val("done_clear", 64'(refill_done), 64'd0);
        check_val("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        resetn = 1'b0; rd_en = 1'b0; rd_set = 3'd0; wr_en = 1'b0; wr_way = 2'd0;
        wr_set = 3'd0; wr_offset = 3'd0; wr_data = 32'd0; wr_strb = 4'd0;
        refill_start = 1'b0; refill_way = 2'd0; refill_set = 3'd0;
        refill_valid = 1'b0; refill_data = 32'd0; refill_last = 1'b0;
        tick(); tick();
        check_val("rst_rd_valid", 64'(rd_valid), 64'd0);
        check_val("rst_rd_data_zero", 64'(rd_data == '0), 64'd1);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_ready", 64'(refill_ready), 64'd0);
        check_val("rst_done", 64'(refill_done), 64'd0);
        check_val("rst_err", 64'(refill_err), 64'd0);
        resetn = 1'b1;
        tick();

        // Test 1: clean refill of way 2 set 5
        start_refill(2'd2, 3'd5);
        send_beats(32'h100, 0, 8, 1'b0, 7);
        finish_commit(1'b0);
        tick();
        read_set(3'd5);
        for (int i = 0; i < LW; i++) check_val("t1_word", 64'(word_of(2, i)), 64'(32'h100 + 32'(i)));
        tick();
        check_val("rd_valid_drop", 64'(rd_valid), 64'd0);
        check_val("rd_data_hold", 64'(word_of(2, 7)), 64'h107);

        // Test 2: strobed store-hit merge
        check_val("wr_ready_idle", 64'(wr_ready), 64'd1);
        do_write(2'd2, 3'd5, 3'd3, 32'hAABBCCDD, 4'b0101);
        read_set(3'd5);
        check_val("t2_merge", 64'(word_of(2, 3)), 64'h00BB01DD);
        check_val("t2_w2", 64'(word_of(2, 2)), 64'h102);
        check_val("t2_w4", 64'(word_of(2, 4)), 64'h104);

        // Test 3: gapped beats, early last on beat 3, into way 1 set 5
        start_refill(2'd1, 3'd5);
        send_beats(32'h200, 0, 8, 1'b1, 3);
        finish_commit(1'b1);
        tick();
        read_set(3'd5);
        check_val("t3_w0", 64'(word_of(1, 0)), 64'h200);
        check_val("t3_w3", 64'(word_of(1, 3)), 64'h203);
        check_val("t3_w7", 64'(word_of(1, 7)), 64'h207);
        check_val("t3_way2_kept", 64'(word_of(2, 3)), 64'h00BB01DD);

        // Test 4: store blocked and old data visible during FILL
        start_refill(2'd2, 3'd5);
        send_beats(32'h300, 0, 4, 1'b0, 7);
        wr_en = 1'b1; wr_way = 2'd2; wr_set = 3'd5; wr_offset = 3'd0;
        wr_data = 32'hDEADBEEF; wr_strb = 4'hF;
        check_val("t4_wr_ready", 64'(wr_ready), 64'd0);
        tick();
        wr_en = 1'b0;
        read_set(3'd5);
        check_val("t4_old_w0", 64'(word_of(2, 0)), 64'h100);
        check_val("t4_old_w5", 64'(word_of(2, 5)), 64'h105);
        send_beats(32'h300, 4, 4, 1'b0, 7);
        finish_commit(1'b0);
        read_set(3'd5);
        check_val("t4_new_w0", 64'(word_of(2, 0)), 64'h300);
        check_val("t4_new_w3", 64'(word_of(2, 3)), 64'h303);

        // Test 5: read-before-write on the same edge
        do_write(2'd0, 3'd1, 3'd0, 32'h12345678, 4'hF);
        wr_en = 1'b1; wr_way = 2'd0; wr_set = 3'd1; wr_offset = 3'd0;
        wr_data = 32'hFFFFFFFF; wr_strb = 4'hF;
        rd_en = 1'b1; rd_set = 3'd1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check_val("t5_old", 64'(word_of(0, 0)), 64'h12345678);
        read_set(3'd1);
        check_val("t5_new", 64'(word_of(0, 0)), 64'hFFFFFFFF);

        // Test 6: reset mid-FILL discards the partial line
        start_refill(2'd1, 3'd5);
        send_beats(32'h400, 0, 4, 1'b0, 7);
        resetn = 1'b0;
        tick();
        check_val("t6_busy", 64'(busy), 64'd0);
        check_val("t6_done", 64'(refill_done), 64'd0);
        check_val("t6_ready", 64'(refill_ready), 64'd0);
        resetn = 1'b1;
        tick();
        check_val("t6_done_after", 64'(refill_done), 64'd0);
        read_set(3'd5);
        check_val("t6_kept_w0", 64'(word_of(1, 0)), 64'h200);
        check_val("t6_kept_w3", 64'(word_of(1, 3)), 64'h203);
        start_refill(2'd1, 3'd5);
        send_beats(32'h500, 0, 8, 1'b0, 7);
        finish_commit(1'b0);
        read_set(3'd5);
        check_val("t6_new_w0", 64'(word_of(1, 0)), 64'h500);
        check_val("t6_new_w5", 64'(word_of(1, 5)), 64'h505);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
